pe_accum_ctrl: RTL and testbench

PE_ACCUM_CTRL -- requirements
Module: pe_accum_ctrl

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_acc_fit.sv | 19 +
 rtl/pe_accum_ctrl.sv | 121 ++++++++++++
 tb/tb_pe_accum_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state type, adder select codes and default width for pe_accum_ctrl
package pe_pkg;

    localparam int PE_WIDTH = 8;

    localparam logic [1:0] SEL_ACCUM = 2'b01;
    localparam logic [1:0] SEL_PSUM  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        OUT
    } pe_state_t;

endpackage

// File: rtl/pe_acc_fit.sv
// rtl/pe_acc_fit.sv - folds a WIDTH+2 adder result into the WIDTH-bit accumulator
// PE_ACC_SAT_EN: clamp to all-ones on overflow; otherwise keep the low WIDTH bits.
module pe_acc_fit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] r_data,
    output logic [WIDTH-1:0] acc_next
);

`ifdef PE_ACC_SAT_EN
    assign acc_next = (|r_data[WIDTH+1:WIDTH]) ? {WIDTH{1'b1}} : r_data[WIDTH-1:0];
`else
    // Upper bits are deliberately dropped in wrap-around mode.
    logic unused_hi;
    assign unused_hi = ^r_data[WIDTH+1:WIDTH];
    assign acc_next  = r_data[WIDTH-1:0];
`endif

endmodule

// File: rtl/pe_accum_ctrl.sv
// rtl/pe_accum_ctrl.sv - sequences accumulate/psum tokens to an external adder over one window
// Overflow behaviour of the accumulator is selected by PE_ACC_SAT_EN (see pe_acc_fit).
module pe_accum_ctrl
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int TAP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TAP_W-1:0]   cfg_taps,
    output logic               sel_valid,
    input  logic               sel_ready,
    output logic [1:0]         sel_data,
    output logic               a0_valid,
    input  logic               a0_ready,
    output logic [WIDTH-1:0]   a0_data,
    input  logic               r_valid,
    output logic               r_ready,
    input  logic [WIDTH+1:0]   r_data,
    output logic               psum_valid,
    input  logic               psum_ready,
    output logic [WIDTH+1:0]   psum_data,
    output logic               busy,
    output logic               done
);

    pe_state_t        state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] fit_val;
    logic [TAP_W-1:0] tap_cnt;
    logic [TAP_W-1:0] taps;
    logic [TAP_W-1:0] cfg_eff;
    logic [TAP_W:0]   next_cnt;
    logic [TAP_W:0]   last_idx;
    logic             cfg_multi;

    pe_acc_fit #(.WIDTH(WIDTH)) u_fit (
        .r_data   (r_data),
        .acc_next (fit_val)
    );

    localparam logic [TAP_W-1:0] TAP_ONE = {{(TAP_W-1){1'b0}}, 1'b1};

    // A zero tap count is treated as a single psum-only step.
    assign cfg_eff   = (cfg_taps == '0) ? TAP_ONE : cfg_taps;
    assign cfg_multi = (cfg_taps > TAP_ONE);
    assign next_cnt  = {1'b0, tap_cnt} + {1'b0, TAP_ONE};
    assign last_idx  = {1'b0, taps} - {1'b0, TAP_ONE};
    assign a0_data   = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            tap_cnt    <= '0;
            taps       <= '0;
            sel_valid  <= 1'b0;
            sel_data   <= 2'b00;
            a0_valid   <= 1'b0;
            r_ready    <= 1'b0;
            psum_valid <= 1'b0;
            psum_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        tap_cnt   <= '0;
                        taps      <= cfg_eff;
                        busy      <= 1'b1;
                        sel_valid <= 1'b1;
                        sel_data  <= cfg_multi ? SEL_ACCUM : SEL_PSUM;
                        a0_valid  <= cfg_multi;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_valid && sel_ready) sel_valid <= 1'b0;
                    if (a0_valid && a0_ready)   a0_valid  <= 1'b0;
                    // Leave once every presented channel has transferred, now or earlier.
                    if ((!sel_valid || sel_ready) && (!a0_valid || a0_ready)) begin
                        r_ready <= 1'b1;
                        state   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (r_valid && r_ready) begin
                        r_ready <= 1'b0;
                        if (sel_data == SEL_ACCUM) begin
                            acc       <= fit_val;
                            tap_cnt   <= next_cnt[TAP_W-1:0];
                            sel_valid <= 1'b1;
                            sel_data  <= (next_cnt < last_idx) ? SEL_ACCUM : SEL_PSUM;
                            a0_valid  <= (next_cnt < last_idx);
                            state     <= ISSUE;
                        end else begin
                            psum_data  <= r_data;
                            psum_valid <= 1'b1;
                            state      <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (psum_valid && psum_ready) begin
                        psum_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// tb/tb_pe_accum_ctrl.sv - directed self-checking bench for pe_accum_ctrl
module tb_pe_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] cfg_taps;
    logic       sel_valid;
    logic       sel_ready;
    logic [1:0] sel_data;
    logic       a0_valid;
    logic       a0_ready;
    logic [7:0] a0_data;
    logic       r_valid;
    logic       r_ready;
    logic [9:0] r_data;
    logic       psum_valid;
    logic       psum_ready;
    logic [9:0] psum_data;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

`ifdef PE_ACC_SAT_EN
    localparam logic [31:0] SAT_EXP = 32'd255;
`else
    localparam logic [31:0] SAT_EXP = 32'd44;
`endif

    pe_accum_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_taps   (cfg_taps),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_data   (sel_data),
        .a0_valid   (a0_valid),
        .a0_ready   (a0_ready),
        .a0_data    (a0_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_data  (psum_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_sel_valid"}, 32'(sel_valid), 0);
        chk({pfx, "_sel_data"}, 32'(sel_data), 0);
        chk({pfx, "_a0_valid"}, 32'(a0_valid), 0);
        chk({pfx, "_a0_data"}, 32'(a0_data), 0);
        chk({pfx, "_r_ready"}, 32'(r_ready), 0);
        chk({pfx, "_psum_valid"}, 32'(psum_valid), 0);
        chk({pfx, "_psum_data"}, 32'(psum_data), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
    endtask

    task automatic do_start(input logic [3:0] c);
        cfg_taps = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("start_busy", 32'(busy), 1);
    endtask

    // One SEL (+A0) issue followed by one adder result; d = extra cycles A0 waits after SEL.
    task automatic step(input logic [1:0] es, input logic [31:0] ea0, input logic [31:0] rv, input int d);
        int n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        chk("sel_valid", 32'(sel_valid), 1);
        chk("sel_data", 32'(sel_data), 32'(es));
        chk("a0_valid", 32'(a0_valid), (es == 2'b01) ? 1 : 0);
        if (es == 2'b01) chk("a0_data", 32'(a0_data), ea0);
        chk("r_ready_issue", 32'(r_ready), 0);
        sel_ready = 1'b1;
        a0_ready  = (d == 0);
        tick();
        sel_ready = 1'b0;
        for (int i = 0; i < d; i++) begin
            chk("sel_not_reissued", 32'(sel_valid), 0);
            chk("a0_still_valid", 32'(a0_valid), 1);
            chk("a0_stable", 32'(a0_data), ea0);
            chk("no_wait_r_yet", 32'(r_ready), 0);
            r_valid = 1'b1;
            r_data  = 10'd1000;
            if (i == d - 1) a0_ready = 1'b1;
            tick();
        end
        a0_ready = 1'b0;
        chk("r_ready", 32'(r_ready), 1);
        r_valid = 1'b1;
        r_data  = rv[9:0];
        tick();
        r_valid = 1'b0;
        chk("r_ready_drop", 32'(r_ready), 0);
        chk("next_valid_lat1", 32'(sel_valid | psum_valid), 1);
    endtask

    task automatic finish_psum(input logic [31:0] ep, input int hold);
        chk("psum_valid", 32'(psum_valid), 1);
        chk("psum_data", 32'(psum_data), ep);
        chk("psum_busy", 32'(busy), 1);
        for (int i = 0; i < hold; i++) begin
            psum_ready = 1'b0;
            start      = (i == 1);
            cfg_taps   = 4'd2;
            tick();
            start = 1'b0;
            chk("psum_hold_valid", 32'(psum_valid), 1);
            chk("psum_hold_data", 32'(psum_data), ep);
            chk("psum_hold_busy", 32'(busy), 1);
            chk("psum_hold_nodone", 32'(done), 0);
            chk("start_ignored_sel", 32'(sel_valid), 0);
        end
        psum_ready = 1'b1;
        tick();
        psum_ready = 1'b0;
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_psum_valid", 32'(psum_valid), 0);
        tick();
        chk("done_once", 32'(done), 0);
        chk("idle_sel", 32'(sel_valid), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_taps   = 4'd0;
        sel_ready  = 1'b0;
        a0_ready   = 1'b0;
        r_valid    = 1'b0;
        r_data     = 10'd0;
        psum_ready = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // taps=3: 01,01,10 with A0 0 then 5; psum 40
        do_start(4'd3);
        chk("start_lat1", 32'(sel_valid), 1);
        step(2'b01, 32'd0, 32'd5, 0);
        step(2'b01, 32'd5, 32'd12, 0);
        step(2'b10, 32'd0, 32'd40, 0);
        finish_psum(32'd40, 0);

        // taps=0 behaves as a single psum step; psum held under backpressure
        do_start(4'd0);
        step(2'b10, 32'd0, 32'd7, 0);
        finish_psum(32'd7, 4);

        // accumulator overflow: 250 then 300
        do_start(4'd4);
        step(2'b01, 32'd0, 32'd250, 0);
        step(2'b01, 32'd250, 32'd300, 0);
        step(2'b01, SAT_EXP, 32'd1, 0);
        step(2'b10, 32'd0, 32'd9, 0);
        finish_psum(32'd9, 0);

        // A0 lags SEL by 3 cycles; stray r_valid meanwhile must be ignored
        do_start(4'd2);
        step(2'b01, 32'd0, 32'd3, 3);
        chk("acc_after_delay", 32'(a0_data), 3);
        step(2'b10, 32'd0, 32'd20, 0);
        finish_psum(32'd20, 0);

        // reset while waiting for the adder
        do_start(4'd3);
        step(2'b01, 32'd0, 32'd9, 0);
        chk("pre_rst_a0", 32'(a0_data), 9);
        sel_ready = 1'b1;
        a0_ready  = 1'b1;
        tick();
        sel_ready = 1'b0;
        a0_ready  = 1'b0;
        chk("pre_rst_wait_r", 32'(r_ready), 1);
        #2 rst_n = 1'b0;
        #1 check_quiet("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_quiet("post_rst");
        do_start(4'd2);
        step(2'b01, 32'd0, 32'd4, 0);
        step(2'b10, 32'd0, 32'd6, 0);
        finish_psum(32'd6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
